csr_access_controller: RTL and testbench

CSR_ACCESS_CONTROLLER -- requirements
Module: csr_access_controller

---
 rtl/csr_access_controller.sv | 175 +++++++++++++++++
 tb/tb_csr_access_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_controller.sv
// CSR access controller: sequences one core CSR access as a single read of the
// register bank, an optional read-modify-write, and a held response to the core.
module csr_access_controller #(
    parameter bit READ_ONLY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        requestValid,
    output logic        requestReady,
    input  logic [11:0] requestAddress,
    input  logic [1:0]  requestOp,
    input  logic [31:0] requestWriteData,
    input  logic        requestWriteSuppress,

    output logic        responseValid,
    input  logic        responseReady,
    output logic [31:0] responseData,
    output logic        responseIllegal,

    output logic        csrReadEnable,
    output logic [11:0] csrReadAddress,
    input  logic [31:0] csrReadData,
    input  logic        csrRequestOutput,

    output logic        csrWriteEnable,
    output logic [11:0] csrWriteAddress,
    output logic [31:0] csrWriteData
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StRespond
    } state_e;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] operand_q, operand_d;
    logic        suppress_q, suppress_d;
    logic [31:0] old_q, old_d;
    logic        illegal_q, illegal_d;

    logic        write_needed;
    logic        read_only_hit;

    // RS/RC with an x0 operand degrade to a pure read.
    assign write_needed  = (op_q == OpWrite) ||
                           (((op_q == OpSet) || (op_q == OpClear)) && !suppress_q);
    assign read_only_hit = READ_ONLY_CHECK && (addr_q[11:10] == 2'b11);

    // State and latched access fields; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            op_q       <= '0;
            operand_q  <= '0;
            suppress_q <= 1'b0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            suppress_q <= suppress_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state and field capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        operand_d  = operand_q;
        suppress_d = suppress_q;
        old_d      = old_q;
        illegal_d  = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (requestValid) begin
                    addr_d     = requestAddress;
                    op_d       = requestOp;
                    operand_d  = requestWriteData;
                    suppress_d = requestWriteSuppress;
                    state_d    = StRead;
                end
            end
            StRead: begin
                old_d = csrReadData;
                if (!csrRequestOutput) begin
                    illegal_d = 1'b1;
                    state_d   = StRespond;
                end else if (write_needed && read_only_hit) begin
                    illegal_d = 1'b1;
                    state_d   = StRespond;
                end else if (write_needed) begin
                    illegal_d = 1'b0;
                    state_d   = StWrite;
                end else begin
                    illegal_d = 1'b0;
                    state_d   = StRespond;
                end
            end
            StWrite: begin
                state_d = StRespond;
            end
            StRespond: begin
                if (responseReady) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state and latched fields only.
    always_comb begin
        requestReady    = 1'b0;
        responseValid   = 1'b0;
        responseData    = '0;
        responseIllegal = 1'b0;
        csrReadEnable   = 1'b0;
        csrReadAddress  = '0;
        csrWriteEnable  = 1'b0;
        csrWriteAddress = '0;
        csrWriteData    = '0;

        unique case (state_q)
            StIdle: begin
                // Reset forces state to idle; keep ready low until it is released.
                requestReady = !rst;
            end
            StRead: begin
                csrReadEnable  = 1'b1;
                csrReadAddress = addr_q;
            end
            StWrite: begin
                csrWriteEnable  = 1'b1;
                csrWriteAddress = addr_q;
                case (op_q)
                    OpSet:   csrWriteData = old_q | operand_q;
                    OpClear: csrWriteData = old_q & ~operand_q;
                    default: csrWriteData = operand_q;
                endcase
            end
            StRespond: begin
                responseValid   = 1'b1;
                responseIllegal = illegal_q;
                responseData    = illegal_q ? 32'h0 : old_q;
            end
            default: begin
                requestReady = 1'b0;
            end
        endcase
    end

    // OpRead is named for readability of the op encoding only.
    logic unused_op_read;
    assign unused_op_read = ^OpRead;

endmodule

// File: tb/tb_csr_access_controller.sv
// Randomized scoreboard bench for csr_access_controller with a behavioural CSR bank.
module tb_csr_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        requestValid;
    logic        requestReady;
    logic [11:0] requestAddress;
    logic [1:0]  requestOp;
    logic [31:0] requestWriteData;
    logic        requestWriteSuppress;
    logic        responseValid;
    logic        responseReady;
    logic [31:0] responseData;
    logic        responseIllegal;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;

    always #5 clk = ~clk;

    csr_access_controller #(.READ_ONLY_CHECK(1'b1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .requestValid         (requestValid),
        .requestReady         (requestReady),
        .requestAddress       (requestAddress),
        .requestOp            (requestOp),
        .requestWriteData     (requestWriteData),
        .requestWriteSuppress (requestWriteSuppress),
        .responseValid        (responseValid),
        .responseReady        (responseReady),
        .responseData         (responseData),
        .responseIllegal      (responseIllegal),
        .csrReadEnable        (csrReadEnable),
        .csrReadAddress       (csrReadAddress),
        .csrReadData          (csrReadData),
        .csrRequestOutput     (csrRequestOutput),
        .csrWriteEnable       (csrWriteEnable),
        .csrWriteAddress      (csrWriteAddress),
        .csrWriteData         (csrWriteData)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        bit          illegal;
        bit          wr;
        int          acc_cyc;
        logic [31:0] prev;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t        expq[$];
    wr_t         wrq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit [31:0]   bank[4096];
    bit [31:0]   ref_mem[4096];
    bit          rv_prev = 1'b0;
    bit          rr_prev = 1'b0;
    logic [31:0] rd_prev = '0;
    logic        ri_prev = 1'b0;

    // Registers exist everywhere except 0x123 and any address ending in 0xF.
    function automatic bit hit_of(logic [11:0] a);
        return (a != 12'h123) && (a[3:0] != 4'hF);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ready"}, {31'b0, requestReady}, 32'h0);
        check({tag, "_flags"}, {28'b0, responseValid, responseIllegal, csrReadEnable,
                                csrWriteEnable}, 32'h0);
        check({tag, "_rdata"}, responseData, 32'h0);
        check({tag, "_addrs"}, {8'b0, csrReadAddress, csrWriteAddress}, 32'h0);
        check({tag, "_wdata"}, csrWriteData, 32'h0);
    endtask

    // Behavioural CSR bank: non-selected registers contribute zero.
    assign csrRequestOutput = csrReadEnable && hit_of(csrReadAddress);
    assign csrReadData      = csrRequestOutput ? bank[csrReadAddress] : 32'h0;

    always @(posedge clk) begin
        if (csrWriteEnable && hit_of(csrWriteAddress)) bank[csrWriteAddress] <= csrWriteData;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the architectural effect of one CSR instruction.
    task automatic model_accept(logic [11:0] a, logic [1:0] op, logic [31:0] d, bit sup);
        exp_t e;
        wr_t  w;
        bit   wn;
        bit   hit;
        logic [31:0] old;
        hit       = hit_of(a);
        wn        = (op == 2'd1) || (op >= 2'd2 && !sup);
        old       = hit ? ref_mem[a] : 32'h0;
        e.addr    = a;
        e.prev    = ref_mem[a];
        e.acc_cyc = cyc;
        e.illegal = !hit || (wn && a >= 12'hC00);
        e.data    = e.illegal ? 32'h0 : old;
        e.wr      = wn && !e.illegal;
        if (e.wr) begin
            w.addr = a;
            if (op == 2'd1)      w.data = d;
            else if (op == 2'd2) w.data = old | d;
            else                 w.data = old & ~d;
            ref_mem[a] = w.data;
            wrq.push_back(w);
        end
        expq.push_back(e);
    endtask

    // Monitor: records accepts and checks every strobe and response against the queues.
    always @(negedge clk) begin
        if (rst) begin
            rv_prev = 1'b0;
            rr_prev = 1'b0;
        end else begin
            if (csrReadEnable) begin
                rd_cnt++;
                if (expq.size() != 0) check("rd_addr", {20'b0, csrReadAddress},
                                            {20'b0, expq[0].addr});
            end else if (csrReadAddress != 12'h0) begin
                check("rd_addr_idle", {20'b0, csrReadAddress}, 32'h0);
            end

            if (csrWriteEnable) begin
                wr_cnt++;
                if (wrq.size() == 0) begin
                    check("unexpected_write", 32'h1, 32'h0);
                end else begin
                    check("wr_addr", {20'b0, csrWriteAddress}, {20'b0, wrq[0].addr});
                    check("wr_data", csrWriteData, wrq[0].data);
                    void'(wrq.pop_front());
                end
            end else if (csrWriteAddress != 12'h0 || csrWriteData != 32'h0) begin
                check("wr_idle_zero", {csrWriteAddress, csrWriteData[19:0]}, 32'h0);
            end

            if (responseValid) begin
                if (expq.size() == 0) begin
                    check("unexpected_response", 32'h1, 32'h0);
                end else begin
                    if (!rv_prev) begin
                        check("latency", cyc - expq[0].acc_cyc, expq[0].wr ? 3 : 2);
                        check("read_strobes", rd_cnt, 1);
                        check("write_strobes", wr_cnt, expq[0].wr ? 1 : 0);
                    end else if (!rr_prev) begin
                        check("hold_data", responseData, rd_prev);
                        check("hold_illegal", {31'b0, responseIllegal}, {31'b0, ri_prev});
                    end
                    if (responseReady) begin
                        check("resp_data", responseData, expq[0].data);
                        check("resp_illegal", {31'b0, responseIllegal},
                              {31'b0, expq[0].illegal});
                        void'(expq.pop_front());
                    end
                end
            end

            if (requestValid && requestReady) begin
                model_accept(requestAddress, requestOp, requestWriteData, requestWriteSuppress);
                rd_cnt = 0;
                wr_cnt = 0;
            end

            rv_prev = responseValid;
            rr_prev = responseReady;
            rd_prev = responseData;
            ri_prev = responseIllegal;
        end
    end

    // Issue one access from posedge+1, hold the response for 'hold' cycles, return at posedge+1.
    task automatic access(logic [11:0] a, logic [1:0] op, logic [31:0] d, bit sup, int hold);
        bit done;
        int held;
        requestValid         = 1'b1;
        requestAddress       = a;
        requestOp            = op;
        requestWriteData     = d;
        requestWriteSuppress = sup;
        responseReady        = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (requestReady) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            check("accept_timeout", 32'h1, 32'h0);
            return;
        end
        done = 1'b0;
        held = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge clk);
            #1;
            // Noise on the request side while busy must be ignored.
            requestValid         = 1'($urandom_range(0, 1));
            requestAddress       = 12'($urandom);
            requestOp            = 2'($urandom);
            requestWriteData     = $urandom;
            requestWriteSuppress = 1'($urandom);
            if (responseValid) begin
                if (held >= hold) begin
                    responseReady = 1'b1;
                    requestValid  = 1'b0;
                end else begin
                    held++;
                end
            end
            @(negedge clk);
            if (responseValid && responseReady) done = 1'b1;
        end
        if (!done) check("response_timeout", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        responseReady = 1'b0;
        requestValid  = 1'b0;
    endtask

    // Start an RW, assert reset in its write cycle, then confirm a clean restart.
    task automatic reset_in_write();
        bit done;
        requestValid         = 1'b1;
        requestAddress       = 12'h301;
        requestOp            = 2'd1;
        requestWriteData     = 32'hDEAD_BEEF;
        requestWriteSuppress = 1'b0;
        responseReady        = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (requestReady) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        requestValid = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 5 && !done; n++) begin
            @(negedge clk);
            if (csrWriteEnable) done = 1'b1;
        end
        check("rst_test_write_seen", {31'b0, done}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_in_write");
        if (expq.size() != 0) begin
            ref_mem[expq[0].addr] = expq[0].prev;
            expq.delete();
        end
        wrq.delete();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        responseReady = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_abort", {31'b0, requestReady}, 32'h1);
        check("no_write_on_abort", bank[12'h301], ref_mem[12'h301]);
        access(12'h301, 2'd0, 32'h0, 1'b0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] alist[10];
        rst                  = 1'b1;
        requestValid         = 1'b0;
        requestAddress       = '0;
        requestOp            = '0;
        requestWriteData     = '0;
        requestWriteSuppress = 1'b0;
        responseReady        = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            bank[i]    = $urandom;
            ref_mem[i] = bank[i];
        end
        bank[12'h300]    = 32'h0000_1888;
        ref_mem[12'h300] = 32'h0000_1888;
        bank[12'hC00]    = 32'h0000_0055;
        ref_mem[12'hC00] = 32'h0000_0055;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'b0, requestReady}, 32'h1);

        // Directed cases.
        access(12'h300, 2'd0, 32'h0, 1'b0, 0);
        access(12'h300, 2'd3, 32'h8, 1'b0, 0);
        access(12'h300, 2'd2, 32'h8, 1'b0, 0);
        access(12'h123, 2'd1, 32'h1234_5678, 1'b0, 0);
        access(12'hC00, 2'd1, 32'hFFFF_FFFF, 1'b0, 0);
        access(12'hC00, 2'd2, 32'hFFFF_FFFF, 1'b1, 0);
        access(12'h300, 2'd0, 32'h0, 1'b0, 5);
        access(12'h300, 2'd1, 32'hA5A5_0000, 1'b0, 0);
        check("final_0x300", bank[12'h300], 32'hA5A5_0000);
        reset_in_write();

        // Randomized traffic over a mix of legal, missing and read-only addresses.
        alist = '{12'h300, 12'h301, 12'h305, 12'h123, 12'hC00,
                  12'hC01, 12'hC3F, 12'h30F, 12'h7FF, 12'hFFE};
        for (int i = 0; i < 150; i++) begin
            logic [11:0] a;
            if ($urandom_range(0, 9) == 0) a = 12'($urandom);
            else a = alist[$urandom_range(0, 9)];
            access(a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("expq_drained", expq.size(), 0);
        check("wrq_drained", wrq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
